fb_rect_writer: RTL and testbench

- Write-side engine for the VGA overlay frame buffer.
- Accepts rectangle-fill and full-clear commands over a valid/ready handshake.
- Emits one pixel write per clock (WRITE_EN/WRITE_ADDR/WRITE_DATA) into the frame buffer's write port, in raster order.
- Sits between game logic (paddles, ball, score) and the frame buffer; its clock is the frame buffer's WRITE_CLK.

---
 rtl/fb_rect_writer_if.sv | 31 +++
 rtl/fb_rect_writer.sv | 139 +++++++++++++
 tb/tb_fb_rect_writer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_rect_writer_if.sv
// Command and pixel-write bundle for the frame buffer rectangle writer.
// The master side issues commands; the slave side performs the writes.
interface fb_rect_writer_if #(
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 24,
    parameter int COORD_WIDTH = 10
);
    logic                   CMD_VALID;
    logic                   CMD_READY;
    logic                   CMD_CLEAR;
    logic [COORD_WIDTH-1:0] CMD_X;
    logic [COORD_WIDTH-1:0] CMD_Y;
    logic [COORD_WIDTH-1:0] CMD_W;
    logic [COORD_WIDTH-1:0] CMD_H;
    logic [DATA_WIDTH-1:0]  CMD_COLOR;
    logic                   WRITE_EN;
    logic [ADDR_WIDTH-1:0]  WRITE_ADDR;
    logic [DATA_WIDTH-1:0]  WRITE_DATA;
    logic                   BUSY;
    logic                   DONE;

    modport master (
        output CMD_VALID, CMD_CLEAR, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR,
        input  CMD_READY, WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY, DONE
    );

    modport slave (
        input  CMD_VALID, CMD_CLEAR, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR,
        output CMD_READY, WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY, DONE
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill / full-clear write engine: one clipped pixel write per clock in raster order.
// First write two cycles after acceptance; commands are only taken in IDLE (CMD_READY).
module fb_rect_writer #(
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 24,
    parameter int COORD_WIDTH = 10
) (
    input  logic             WRITE_CLK,
    input  logic             RESET,
    fb_rect_writer_if.slave  bus
);
    localparam int CW = COORD_WIDTH;
    localparam logic [CW:0]           FBW_C  = (CW+1)'(FB_WIDTH);
    localparam logic [CW:0]           FBH_C  = (CW+1)'(FB_HEIGHT);
    localparam logic [CW:0]           ONE_C  = (CW+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] FBW_A  = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, FINISH} state_t;
    state_t state, state_nxt;

    logic                  clr_q;
    logic [CW-1:0]         x_q, y_q, w_q, h_q;
    logic [DATA_WIDTH-1:0] color_q;

    logic [CW:0]           span_w_q, col_left, row_left;
    logic [ADDR_WIDTH-1:0] row_base, addr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [CW:0]           x_end, y_end, x0, y0, x1, y1, span_w, span_h;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  last_pix;

    // Clipping: sums are one bit wider than the fields so X+W never wraps.
    always_comb begin
        x_end = {1'b0, x_q} + {1'b0, w_q};
        y_end = {1'b0, y_q} + {1'b0, h_q};
        if (clr_q) begin
            x0    = '0;
            y0    = '0;
            x1    = FBW_C;
            y1    = FBH_C;
            empty = 1'b0;
        end else begin
            x0    = {1'b0, x_q};
            y0    = {1'b0, y_q};
            x1    = (x_end < FBW_C) ? x_end : FBW_C;
            y1    = (y_end < FBH_C) ? y_end : FBH_C;
            empty = (w_q == '0) || (h_q == '0) || (x0 >= FBW_C) || (y0 >= FBH_C);
        end
        span_w     = x1 - x0;
        span_h     = y1 - y0;
        start_addr = ADDR_WIDTH'(y0) * FBW_A + ADDR_WIDTH'(x0);
    end

    assign last_pix = (col_left == '0) && (row_left == '0);

    always_ff @(posedge WRITE_CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.CMD_VALID) state_nxt = SETUP;
            SETUP:   state_nxt = empty ? FINISH : FILL;
            FILL:    if (last_pix) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge WRITE_CLK) begin
        if (RESET) begin
            clr_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            span_w_q <= '0;
            col_left <= '0;
            row_left <= '0;
            row_base <= '0;
            addr     <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_en <= (state_nxt == FILL);
            case (state)
                IDLE: begin
                    if (bus.CMD_VALID) begin
                        clr_q   <= bus.CMD_CLEAR;
                        x_q     <= bus.CMD_X;
                        y_q     <= bus.CMD_Y;
                        w_q     <= bus.CMD_W;
                        h_q     <= bus.CMD_H;
                        color_q <= bus.CMD_COLOR;
                    end
                end
                SETUP: begin
                    // An empty command leaves the write port untouched.
                    if (!empty) begin
                        addr     <= start_addr;
                        row_base <= start_addr;
                        span_w_q <= span_w;
                        col_left <= span_w - ONE_C;
                        row_left <= span_h - ONE_C;
                        wr_data  <= color_q;
                    end
                end
                FILL: begin
                    if (col_left != '0) begin
                        addr     <= addr + ONE_A;
                        col_left <= col_left - ONE_C;
                    end else if (row_left != '0) begin
                        row_base <= row_base + FBW_A;
                        addr     <= row_base + FBW_A;
                        col_left <= span_w_q - ONE_C;
                        row_left <= row_left - ONE_C;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.CMD_READY  = (state == IDLE);
    assign bus.BUSY       = (state != IDLE);
    assign bus.DONE       = (state == FINISH);
    assign bus.WRITE_EN   = wr_en;
    assign bus.WRITE_ADDR = addr;
    assign bus.WRITE_DATA = wr_data;
endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: a full-size 640x480 instance and a 20x12 instance for full clears.
module tb_fb_rect_writer;
    localparam int B_W = 640;
    localparam int B_H = 480;
    localparam int S_W = 20;
    localparam int S_H = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_rect_writer_if #(.ADDR_WIDTH(19), .DATA_WIDTH(24), .COORD_WIDTH(10)) b_if ();
    fb_rect_writer_if #(.ADDR_WIDTH(8),  .DATA_WIDTH(24), .COORD_WIDTH(5))  s_if ();

    fb_rect_writer #(.FB_WIDTH(B_W), .FB_HEIGHT(B_H), .ADDR_WIDTH(19), .DATA_WIDTH(24), .COORD_WIDTH(10))
        u_big (.WRITE_CLK(clk), .RESET(rst), .bus(b_if));
    fb_rect_writer #(.FB_WIDTH(S_W), .FB_HEIGHT(S_H), .ADDR_WIDTH(8), .DATA_WIDTH(24), .COORD_WIDTH(5))
        u_small (.WRITE_CLK(clk), .RESET(rst), .bus(s_if));

    logic        sel, c_valid, c_clear;
    logic [9:0]  c_x, c_y, c_w, c_h;
    logic [23:0] c_col;

    assign b_if.CMD_VALID = c_valid & ~sel;
    assign b_if.CMD_CLEAR = c_clear;
    assign b_if.CMD_X     = c_x;
    assign b_if.CMD_Y     = c_y;
    assign b_if.CMD_W     = c_w;
    assign b_if.CMD_H     = c_h;
    assign b_if.CMD_COLOR = c_col;
    assign s_if.CMD_VALID = c_valid & sel;
    assign s_if.CMD_CLEAR = c_clear;
    assign s_if.CMD_X     = c_x[4:0];
    assign s_if.CMD_Y     = c_y[4:0];
    assign s_if.CMD_W     = c_w[4:0];
    assign s_if.CMD_H     = c_h[4:0];
    assign s_if.CMD_COLOR = c_col;

    logic        o_en, o_ready, o_busy, o_done;
    logic [18:0] o_addr;
    logic [23:0] o_data;
    assign o_en    = sel ? s_if.WRITE_EN  : b_if.WRITE_EN;
    assign o_ready = sel ? s_if.CMD_READY : b_if.CMD_READY;
    assign o_busy  = sel ? s_if.BUSY      : b_if.BUSY;
    assign o_done  = sel ? s_if.DONE      : b_if.DONE;
    assign o_addr  = sel ? {11'b0, s_if.WRITE_ADDR} : b_if.WRITE_ADDR;
    assign o_data  = sel ? s_if.WRITE_DATA : b_if.WRITE_DATA;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: the expected write list is every pixel of the clipped rectangle in raster order.
    task automatic run_cmd(input bit sl, input bit clr, input int x, input int y, input int w, input int h,
                           input logic [23:0] col, input string nm,
                           output int n_obs, output int first_a, output int last_a);
        int fbw, fbh, x1, y1, n, t, bad;
        int ex[$];
        logic [18:0] prev_addr;
        fbw = sl ? S_W : B_W;
        fbh = sl ? S_H : B_H;
        if (clr) begin
            for (int yy = 0; yy < fbh; yy++)
                for (int xx = 0; xx < fbw; xx++) ex.push_back(yy * fbw + xx);
        end else if (w > 0 && h > 0 && x < fbw && y < fbh) begin
            x1 = (x + w > fbw) ? fbw : x + w;
            y1 = (y + h > fbh) ? fbh : y + h;
            for (int yy = y; yy < y1; yy++)
                for (int xx = x; xx < x1; xx++) ex.push_back(yy * fbw + xx);
        end
        n = ex.size();
        @(negedge clk);
        sel = sl;
        #1;
        t = 0;
        while (!o_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({nm, "_ready"}, o_ready, 1);
        prev_addr = o_addr;
        c_valid = 1'b1; c_clear = clr;
        c_x = 10'(x); c_y = 10'(y); c_w = 10'(w); c_h = 10'(h); c_col = col;
        @(posedge clk);
        #1;
        c_valid = 1'b0; c_clear = 1'($urandom);
        c_x = 10'($urandom); c_y = 10'($urandom); c_w = 10'($urandom); c_h = 10'($urandom);
        c_col = 24'($urandom);
        n_obs = 0; first_a = -1; last_a = -1; bad = 0;
        for (int j = 0; j < n + 3; j++) begin
            @(negedge clk);
            if (o_en) begin
                n_obs++;
                if (first_a < 0) first_a = int'(o_addr);
                last_a = int'(o_addr);
            end
            if (j == 0)
                chk({nm, "_setup"}, {o_en, o_busy, o_ready, o_done}, 4'b0100);
            else if (j <= n) begin
                if (!o_en || int'(o_addr) != ex[j-1] || o_data != col || o_done || o_ready) bad++;
            end else if (j == n + 1) begin
                chk({nm, "_done"}, {o_en, o_done, o_ready}, 3'b010);
                chk({nm, "_addr_hold"}, o_addr, (n > 0) ? longint'(ex[n-1]) : longint'(prev_addr));
            end else
                chk({nm, "_back_idle"}, {o_ready, o_busy, o_done}, 3'b100);
        end
        chk({nm, "_bad_writes"}, bad, 0);
        chk({nm, "_model_count"}, n_obs, n);
    endtask

    typedef struct {
        bit          sl;
        bit          clr;
        int          x, y, w, h;
        logic [23:0] col;
        int          exp_n, exp_first, exp_last;
        string       nm;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n_obs, fa, la, busy_seen, en_seen, done_seen;
        tbl[0]  = '{0, 0,   10,   2,    3,    2, 24'hFF00FF,   6,   1290,   1932, "rect_basic"};
        tbl[1]  = '{0, 0,  638, 479,    5,    4, 24'h00FF00,   2, 307198, 307199, "rect_clip_corner"};
        tbl[2]  = '{0, 0,    5,   5,    0,    3, 24'h111111,   0,     -1,     -1, "empty_w0"};
        tbl[3]  = '{0, 0,  700,   0,    5,    5, 24'h222222,   0,     -1,     -1, "empty_x700"};
        tbl[4]  = '{0, 0,    5,   5,    3,    0, 24'h333333,   0,     -1,     -1, "empty_h0"};
        tbl[5]  = '{0, 0,    0, 480,    1,    1, 24'h444444,   0,     -1,     -1, "empty_y480"};
        tbl[6]  = '{0, 0,    0,   0,    1,    1, 24'h123456,   1,      0,      0, "pix_origin"};
        tbl[7]  = '{0, 0,  639,   0, 1023,    1, 24'hABCDEF,   1,    639,    639, "pix_right_edge"};
        tbl[8]  = '{0, 0,    0, 479,  640,    1, 24'h0F0F0F, 640, 306560, 307199, "last_row"};
        tbl[9]  = '{0, 0, 1023,1023, 1023, 1023, 24'h555555,   0,     -1,     -1, "empty_maxfields"};
        tbl[10] = '{1, 1,    3,   4,    0,    0, 24'h000000, 240,      0,    239, "clear_black"};
        tbl[11] = '{1, 0,   18,  10,   31,   31, 24'h00AA55,   4,    218,    239, "small_clip"};
        tbl[12] = '{1, 1,   31,  31,   31,   31, 24'hC0FFEE, 240,      0,    239, "clear_color"};
        tbl[13] = '{0, 0,   10,   2,    3,    2, 24'h0000FF,   6,   1290,   1932, "rect_back2back"};

        sel = 1'b0; c_valid = 1'b0; c_clear = 1'b0;
        c_x = '0; c_y = '0; c_w = '0; c_h = '0; c_col = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_idle_big", {b_if.CMD_READY, b_if.WRITE_EN, b_if.BUSY, b_if.DONE}, 4'b1000);
            chk("reset_idle_small", {s_if.CMD_READY, s_if.WRITE_EN, s_if.BUSY, s_if.DONE}, 4'b1000);
        end
        chk("reset_addr", b_if.WRITE_ADDR, 0);
        chk("reset_data", b_if.WRITE_DATA, 0);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].sl, tbl[i].clr, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].col,
                    tbl[i].nm, n_obs, fa, la);
            chk({tbl[i].nm, "_count"}, n_obs, tbl[i].exp_n);
            chk({tbl[i].nm, "_first"}, fa, tbl[i].exp_first);
            chk({tbl[i].nm, "_last"}, la, tbl[i].exp_last);
        end

        // Valid held high: the second copy may only be taken after the first one's DONE.
        @(negedge clk);
        sel = 1'b0;
        c_valid = 1'b1; c_clear = 1'b0; c_x = 10'd0; c_y = 10'd5; c_w = 10'd3; c_h = 10'd1;
        c_col = 24'h777777;
        @(posedge clk);
        en_seen = 0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (o_en) en_seen++;
            if (j == 5) chk("hold_valid_idle_gap", {o_ready, o_busy, o_en}, 3'b100);
        end
        c_valid = 1'b0;
        chk("hold_valid_writes", en_seen, 5);
        for (int t = 0; t < 50 && !o_ready; t++) @(negedge clk);
        chk("hold_valid_ready", o_ready, 1);

        // Reset in the middle of a 100x100 fill.
        @(negedge clk);
        c_valid = 1'b1; c_x = 10'd0; c_y = 10'd0; c_w = 10'd100; c_h = 10'd100; c_col = 24'h999999;
        @(posedge clk);
        #1 c_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("rst_fill_writing", o_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_fill_after", {o_en, o_ready, o_busy, o_done}, 4'b0100);
        done_seen = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (o_done || o_en) done_seen++;
        end
        chk("rst_fill_no_done", done_seen, 0);
        run_cmd(0, 0, 0, 0, 1, 1, 24'h010203, "post_reset_pix", n_obs, fa, la);
        chk("post_reset_pix_count", n_obs, 1);
        chk("post_reset_pix_addr", fa, 0);

        // A command presented together with reset must be dropped.
        @(negedge clk);
        rst = 1'b1; c_valid = 1'b1; c_x = 10'd4; c_y = 10'd4; c_w = 10'd2; c_h = 10'd2;
        @(posedge clk);
        #1 begin rst = 1'b0; c_valid = 1'b0; end
        busy_seen = 0; en_seen = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (o_busy) busy_seen++;
            if (o_en) en_seen++;
        end
        chk("valid_with_reset_busy", busy_seen, 0);
        chk("valid_with_reset_writes", en_seen, 0);

        for (int i = 0; i < 40; i++)
            run_cmd(1, ($urandom_range(0, 7) == 0), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), 24'($urandom), "rand_small", n_obs, fa, la);
        for (int i = 0; i < 20; i++)
            run_cmd(0, 1'b0, $urandom_range(560, 700), $urandom_range(440, 500),
                    $urandom_range(0, 60), $urandom_range(0, 10), 24'($urandom), "rand_big", n_obs, fa, la);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
